// File: rtl/yeah_sprite_fetch.sv
// -----------------------------------------------------------------------------
// yeah_sprite_fetch
//
// Pixel-pipeline stage ahead of the sprite palette. It maps the VGA raster
// coordinate to a sprite-ROM address, captures the 4-bit colour index the ROM
// returns, and presents it two cycles later with a hit flag and delayed de.
// The sprite position, mirror flag and animation frame are updated only at
// the start of a frame (vsync falling edge), so the sprite never tears.
//
// Ports:
//   clk        pixel clock
//   reset_n    asynchronous active-low reset
//   draw_x/y   current raster coordinate (10 bit)
//   de         display enable, 1 = active video
//   vs         vsync, active low
//   sprite_x/y requested sprite top-left corner (latched at frame start)
//   flip_h     requested horizontal mirror (latched at frame start)
//   anim_en    1 = animation counter advances on each frame start
//   rom_addr   address to the synchronous sprite ROM (0 when outside sprite)
//   rom_data   ROM colour index, valid one cycle after rom_addr
//   index_out  colour index for the palette (TRANSPARENT_IDX outside sprite)
//   hit        1 = index_out is an opaque sprite pixel
//   de_out     de delayed to line up with index_out
// -----------------------------------------------------------------------------
module yeah_sprite_fetch #(
    parameter int          W               = 32,
    parameter int          H               = 32,
    parameter int          FRAMES          = 4,
    parameter int          HOLD            = 8,
    parameter logic [3:0]  TRANSPARENT_IDX = 4'd0,
    parameter int          AW              = $clog2(W * H * FRAMES)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [9:0]    draw_x,
    input  logic [9:0]    draw_y,
    input  logic          de,
    input  logic          vs,
    input  logic [9:0]    sprite_x,
    input  logic [9:0]    sprite_y,
    input  logic          flip_h,
    input  logic          anim_en,
    output logic [AW-1:0] rom_addr,
    input  logic [3:0]    rom_data,
    output logic [3:0]    index_out,
    output logic          hit,
    output logic          de_out
);

    localparam int XB = $clog2(W);
    localparam int YB = $clog2(H);
    // Counters keep at least one bit so single-frame / single-hold builds stay legal.
    localparam int FB = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int HB = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [XB-1:0] COL_MAX   = XB'(W - 1);
    localparam logic [FB-1:0] FRAME_MAX = FB'(FRAMES - 1);
    localparam logic [HB-1:0] HOLD_MAX  = HB'(HOLD - 1);

    // Frame-start detection and per-frame state
    logic          vs_q;
    logic          frame_start;
    logic [9:0]    pos_x_q;
    logic [9:0]    pos_y_q;
    logic          flip_q;
    logic [FB-1:0] frame_cnt;
    logic [HB-1:0] hold_cnt;

    // Stage 0
    logic [10:0]         dx;
    logic [10:0]         dy;
    logic                in_box;
    logic [XB-1:0]       col;
    logic [FB+YB+XB-1:0] addr_full;

    // Stage 1
    logic s1_box;
    logic s1_de;

    assign frame_start = vs_q & ~vs;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_q      <= 1'b1;   // idle-high so release never looks like a falling edge
            pos_x_q   <= '0;
            pos_y_q   <= '0;
            flip_q    <= 1'b0;
            frame_cnt <= '0;
            hold_cnt  <= '0;
        end else begin
            vs_q <= vs;
            if (frame_start) begin
                pos_x_q <= sprite_x;
                pos_y_q <= sprite_y;
                flip_q  <= flip_h;
                if (anim_en) begin
                    if (hold_cnt == HOLD_MAX) begin
                        hold_cnt  <= '0;
                        frame_cnt <= (frame_cnt == FRAME_MAX) ? '0 : frame_cnt + 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // 11-bit differences: a raster position left of / above the sprite wraps
    // to >= 1024 and therefore fails the unsigned box compare.
    assign dx     = {1'b0, draw_x} - {1'b0, pos_x_q};
    assign dy     = {1'b0, draw_y} - {1'b0, pos_y_q};
    assign in_box = de & (dx < 11'(W)) & (dy < 11'(H));

    // W-1-dx, valid because dx < W whenever the address is used
    assign col       = flip_q ? (COL_MAX - dx[XB-1:0]) : dx[XB-1:0];
    assign addr_full = {frame_cnt, dy[YB-1:0], col};
    assign rom_addr  = in_box ? addr_full[AW-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_box    <= 1'b0;
            s1_de     <= 1'b0;
            index_out <= TRANSPARENT_IDX;
            hit       <= 1'b0;
            de_out    <= 1'b0;
        end else begin
            s1_box    <= in_box;
            s1_de     <= de;
            index_out <= s1_box ? rom_data : TRANSPARENT_IDX;
            hit       <= s1_box & (rom_data != TRANSPARENT_IDX);
            de_out    <= s1_de;
        end
    end

endmodule

// File: doc/yeah_sprite_fetch.md
# yeah_sprite_fetch

Pixel-pipeline stage that sits directly upstream of the `yeah` sprite palette. It turns the VGA controller's current pixel coordinate into a sprite-ROM read address. It captures the 4-bit colour index the ROM returns and hands that index, aligned with a hit flag, to the palette lookup. The stage also owns the sprite's per-frame position and a vsync-driven animation counter, so the sprite never tears mid-frame.

## Interface
Parameters:
- `W`, 32: sprite width in pixels (power of two).
- `H`, 32: sprite height in pixels (power of two).
- `FRAMES`, 4: number of animation frames stored back-to-back in the ROM (power of two).
- `HOLD`, 8: vsync periods each animation frame is displayed (≥1).
- `TRANSPARENT_IDX`, 0: ROM index treated as "no sprite pixel".
- `AW`, log2(W·H·FRAMES): ROM address width.

Ports:
- `clk` in 1: pixel clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `draw_x` in 10: current pixel column.
- `draw_y` in 10: current pixel row.
- `de` in 1: display enable, 1 = active video.
- `vs` in 1: VGA vsync, active-low.
- `sprite_x` in 10: requested sprite top-left column.
- `sprite_y` in 10: requested sprite top-left row.
- `flip_h` in 1: requested horizontal mirror.
- `anim_en` in 1: 1 = animation advances.
- `rom_addr` out AW: address to the synchronous sprite ROM.
- `rom_data` in 4: ROM data, valid one cycle after `rom_addr`.
- `index_out` out 4: colour index for the palette.
- `hit` out 1: 1 = `index_out` is an opaque sprite pixel.
- `de_out` out 1: `de` delayed to align with `index_out`.

## Operation
- Frame-start detect:
  - `vs` is registered once; a frame start is a cycle with `vs_q=1` and `vs=0` (falling edge).
  - Exactly one pulse per vsync.
- Frame latch: on a frame start, `sprite_x`, `sprite_y` and `flip_h` are captured into `pos_x_q`, `pos_y_q` and `flip_q`. All address math uses only these latched copies.
- Animation counter:
  - On a frame start with `anim_en=1`, `hold_cnt` increments.
  - When `hold_cnt` reaches HOLD-1, it clears and `frame_cnt` increments, wrapping FRAMES-1 → 0.
  - With `anim_en=0`, both counters hold their values.
- Stage 0 (combinational):
  - `dx = draw_x - pos_x_q`, `dy = draw_y - pos_y_q`, both computed 11 bits wide.
  - `in_box = de & (dx < W) & (dy < H)`, with each compare unsigned on the 11-bit value, so a negative difference fails.
  - Column `col = flip_q ? W-1-dx : dx`.
  - `rom_addr = frame_cnt·W·H + dy·W + col`, built by bit concatenation.
  - When `in_box=0`, `rom_addr` is 0.
- Stage 1 (register): `in_box` and `de` are registered into `s1_box` and `s1_de`. The ROM delivers `rom_data` in this same cycle.
- Stage 2 (register):
  - `index_out <= s1_box ? rom_data : TRANSPARENT_IDX`.
  - `hit <= s1_box & (rom_data != TRANSPARENT_IDX)`.
  - `de_out <= s1_de`.
- Clipping: a sprite extending past column 639 or row 479 is clipped naturally, because `de`=0 there. Positions up to 1023 are legal.

## Timing
- Reset values:
  - `index_out`=TRANSPARENT_IDX, `hit`=0, `de_out`=0.
  - `rom_addr`=0 (with `de`=0).
  - `pos_x_q`=`pos_y_q`=0, `flip_q`=0.
  - `frame_cnt`=0, `hold_cnt`=0.
  - `vs_q`=1, so no spurious frame start on release.
- Latency: a coordinate presented in cycle N produces `index_out`, `hit` and `de_out` in cycle N+2. Throughput is one pixel per clock with no stalls.
- A frame-start cycle still uses the old latched position and frame; new values take effect in cycle +1.
- `sprite_x`, `sprite_y` and `flip_h` changes between frame starts have no visible effect.
- Reset asserted mid-line: all pipeline registers clear immediately. The first valid output after release is 2 cycles after the first `de=1` input.
- Boundary compares:
  - `dx = W-1` is in the box; `dx = W` is out.
  - `draw_x < pos_x_q` wraps to 11-bit values ≥1024, which are out.

## Test plan
- Reset release, then stimulus `sprite_x=100`, `sprite_y=50`, one vsync falling edge, pixel (100,50) with `de=1` → `rom_addr`=0 in the same cycle; `index_out`=ROM[0] and `hit`=1 (if ROM[0]≠0) exactly 2 cycles later.
- Latched copies default to 0 at reset, so with no vsync edge the sprite stays at (0,0). Driving `sprite_x=200` with no vsync edge, pixel (200,0) → `hit`=0; pixel (5,0) → `hit` follows ROM[5]. After one vsync edge, (200,0) hits.
- `flip_h=1`, pixel at `dx=0`, `dy=3` → `rom_addr` = 3·W + W-1 = 127 (W=32).
- `anim_en=1`, HOLD=8: after 8 vsync edges `frame_cnt`=1, so the pixel at `dx`=`dy`=0 addresses 1024. After 32 edges `frame_cnt` wraps to 0. With `anim_en=0`, 20 edges → count unchanged.
- Edges of the box:
  - `dx=31` hits and `dx=32` misses.
  - `draw_x=99` with `pos_x=100` misses (wrap case).
  - `de=0` inside the box → `hit`=0, `index_out`=0.
- ROM returning TRANSPARENT_IDX inside the box → `hit`=0. Reset pulsed while `hit`=1 → `hit`, `de_out` and counters read 0 on the next clock edge.
